controle_movimento: RTL
=======================

// Module: controle_movimento
// PURPOSE
//  Motion controller for the elevator car. Accepts a target floor, derives direction
//  from sign(andar - alvo) (same rule as direction logic: 1 = sobe, 0 = desce), steps the
//  current-floor register one floor per travel interval, then runs a timed door-open phase.
//  Sits between the request/button logic (upstream) and the motor/door/display drivers.
// PARAMETERS
//  N_ANDARES    10  number of floors, valid floors 0..N_ANDARES-1 (N_ANDARES <= 16)
//  CICLOS_ANDAR 4   clock cycles to travel one floor (>= 1)
//  CICLOS_PORTA 6   clock cycles door stays open (>= 1)
// PORTS
//  clock        in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high
//  pedido       in   1  request valid; sampled only when ocupado = 0
//  andar_alvo   in   4  target floor, qualified by pedido
//  ocupado      out  1  1 = request in service, new pedidos ignored
//  andar        out  4  current floor of the car
//  sobe         out  1  motor up command
//  desce        out  1  motor down command
//  porta_aberta out  1  door open command
//  chegou       out  1  one-cycle pulse on arrival (entry to PORTA)
// BEHAVIOUR
//  States: PARADO, SUBINDO, DESCENDO, PORTA. All outputs registered.
//  Reset (any cycle, incl. mid-travel or door open): state PARADO, andar=0, alvo reg=0,
//   counter=0, ocupado=sobe=desce=porta_aberta=chegou=0. No floor is remembered.
//  PARADO: if pedido=1 and andar_alvo < N_ANDARES, latch alvo; next state from 5-bit
//   subtraction andar - andar_alvo: negative -> SUBINDO, positive -> DESCENDO,
//   zero -> PORTA. Out-of-range andar_alvo: request dropped, stay PARADO, no output change.
//  Acceptance latency: outputs of new state visible one cycle after pedido sampled.
//  SUBINDO/DESCENDO: sobe (resp. desce)=1, ocupado=1. Counter counts 0..CICLOS_ANDAR-1;
//   on terminal count andar +1 (resp. -1) and counter wraps to 0. If the updated andar
//   equals alvo, next state PORTA in that same edge (sobe/desce drop together with step).
//  sobe and desce are never 1 simultaneously; neither is 1 while porta_aberta=1.
//  andar never leaves 0..N_ANDARES-1 (guaranteed by the range check; no wrap).
//  PORTA: porta_aberta=1, ocupado=1, chegou=1 only on first cycle. Stays CICLOS_PORTA
//   cycles, then PARADO with ocupado=0; pedido may be accepted on the first PARADO cycle.
//  pedido while ocupado=1: ignored entirely (no queue, no latching of andar_alvo).
//  Travel time from acceptance to chegou: |andar-alvo| * CICLOS_ANDAR + 1 cycles.
// TESTING (defaults N_ANDARES=10, CICLOS_ANDAR=4, CICLOS_PORTA=6)
//  Reset pulse -> andar=0, ocupado=sobe=desce=porta_aberta=chegou=0 next cycle.
//  From andar=0, pedido 1 cycle with andar_alvo=3 -> sobe=1 for 12 cycles, andar 1,2,3
//   every 4 cycles, chegou pulse at cycle 13, porta_aberta 6 cycles, then ocupado=0.
//  From andar=3, andar_alvo=1 -> desce=1, andar 2 then 1 after 8 cycles, door opens;
//   andar_alvo=3 at andar=3 -> PORTA next cycle, sobe=desce=0 throughout.
//  andar_alvo=12 with pedido=1 while PARADO -> no state change, ocupado stays 0.
//  During SUBINDO to 5, pedido with andar_alvo=0 -> ignored, car still stops at 5.
//  Reset asserted while SUBINDO at andar=2 -> andar=0, sobe=0, PARADO next cycle.

Source files
------------

// File: rtl/controle_movimento.sv
// Elevator car motion controller: accepts a target floor, steps the car one floor per
// travel interval toward it, then holds the door open for a fixed time.
module controle_movimento #(
    parameter int N_ANDARES    = 10,
    parameter int CICLOS_ANDAR = 4,
    parameter int CICLOS_PORTA = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pedido,
    input  logic [3:0] andar_alvo,
    output logic       ocupado,
    output logic [3:0] andar,
    output logic       sobe,
    output logic       desce,
    output logic       porta_aberta,
    output logic       chegou
);

    localparam int CMAX = (CICLOS_ANDAR > CICLOS_PORTA) ? CICLOS_ANDAR : CICLOS_PORTA;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA} estado_t;

    estado_t           estado, estado_n;
    logic [3:0]        alvo, alvo_n, andar_n;
    logic [CW-1:0]     cont, cont_n;
    logic signed [4:0] dif;
    logic              aceita;
    logic              ocupado_n, sobe_n, desce_n, porta_n, chegou_n;

    always_comb begin
        estado_n = estado;
        andar_n  = andar;
        alvo_n   = alvo;
        cont_n   = cont;
        // Sign of andar - alvo decides direction; the extra bit keeps the borrow.
        dif      = $signed({1'b0, andar} - {1'b0, andar_alvo});
        aceita   = pedido && ({1'b0, andar_alvo} < 5'(N_ANDARES));

        case (estado)
            PARADO: begin
                if (aceita) begin
                    alvo_n = andar_alvo;
                    cont_n = '0;
                    if (dif[4])
                        estado_n = SUBINDO;
                    else if (dif != 5'sd0)
                        estado_n = DESCENDO;
                    else
                        estado_n = PORTA;
                end
            end
            SUBINDO: begin
                if (cont == CW'(CICLOS_ANDAR - 1)) begin
                    cont_n  = '0;
                    andar_n = andar + 4'd1;
                    if (andar_n == alvo)
                        estado_n = PORTA;
                end else begin
                    cont_n = cont + CW'(1);
                end
            end
            DESCENDO: begin
                if (cont == CW'(CICLOS_ANDAR - 1)) begin
                    cont_n  = '0;
                    andar_n = andar - 4'd1;
                    if (andar_n == alvo)
                        estado_n = PORTA;
                end else begin
                    cont_n = cont + CW'(1);
                end
            end
            PORTA: begin
                if (cont == CW'(CICLOS_PORTA - 1)) begin
                    cont_n   = '0;
                    estado_n = PARADO;
                end else begin
                    cont_n = cont + CW'(1);
                end
            end
            default: estado_n = PARADO;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        ocupado_n = (estado_n != PARADO);
        sobe_n    = (estado_n == SUBINDO);
        desce_n   = (estado_n == DESCENDO);
        porta_n   = (estado_n == PORTA);
        chegou_n  = (estado_n == PORTA) && (estado != PORTA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= PARADO;
            andar        <= 4'd0;
            alvo         <= 4'd0;
            cont         <= '0;
            ocupado      <= 1'b0;
            sobe         <= 1'b0;
            desce        <= 1'b0;
            porta_aberta <= 1'b0;
            chegou       <= 1'b0;
        end else begin
            estado       <= estado_n;
            andar        <= andar_n;
            alvo         <= alvo_n;
            cont         <= cont_n;
            ocupado      <= ocupado_n;
            sobe         <= sobe_n;
            desce        <= desce_n;
            porta_aberta <= porta_n;
            chegou       <= chegou_n;
        end
    end

endmodule
